// File: rtl/y_adder.sv
// Registered ripple-carry adder built from explicit full-adder cells.
// Optional signed-overflow output is enabled by defining Y_ADDER_OVF_EN.
module y_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module y_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] z,
  output logic             cout,
`ifdef Y_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    y_adder_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z    <= s;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef Y_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_y_adder.sv
// Self-checking bench for y_adder: directed and random operands
// compared against an arithmetic reference model.
module tb_y_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] z;
  logic         cout;
  logic         out_valid;
`ifdef Y_ADDER_OVF_EN
  logic         ovf;
`endif

  logic [W-1:0] ez = '0;
  logic         ecout = 1'b0;
  logic         ev = 1'b0;
  logic         eovf = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  y_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .z         (z),
    .cout      (cout),
`ifdef Y_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  task automatic chk(input string tag);
    total++;
    assert (z === ez) else begin
      bad++;
      $error("FAIL %s z got %h want %h", tag, z, ez);
    end
    total++;
    assert (cout === ecout) else begin
      bad++;
      $error("FAIL %s cout got %b want %b", tag, cout, ecout);
    end
    total++;
    assert (out_valid === ev) else begin
      bad++;
      $error("FAIL %s out_valid got %b want %b", tag, out_valid, ev);
    end
`ifdef Y_ADDER_OVF_EN
    total++;
    assert (ovf === eovf) else begin
      bad++;
      $error("FAIL %s ovf got %b want %b", tag, ovf, eovf);
    end
`endif
  endtask

  task automatic model_reset();
    ez    = '0;
    ecout = 1'b0;
    ev    = 1'b0;
    eovf  = 1'b0;
  endtask

  task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic tv, input string tag);
    logic [W:0] full;
    @(negedge clk);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = tv;
    @(posedge clk);
    if (tv) begin
      full  = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      ez    = full[W-1:0];
      ecout = full[W];
      ev    = 1'b1;
      eovf  = (ta[W-1] == tb[W-1]) && (ez[W-1] != ta[W-1]);
    end else begin
      ev = 1'b0;
    end
    #1;
    chk(tag);
  endtask

  initial begin
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("reset_hold");

    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    step(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, "carry_chain");
    step(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, "plain_sum");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "max_sum");
    step(32'h0, 32'h0, 1'b0, 1'b1, "zero_sum");

    for (int i = 0; i < 24; i++) begin
      step($urandom, $urandom, 1'(i % 2), 1'b1, "random");
    end

    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, "pre_hold");
    step($urandom, $urandom, 1'b1, 1'b0, "hold1");
    step($urandom, $urandom, 1'b0, 1'b0, "hold2");

    step(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, "ovf_pos");
    step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "ovf_neg");
    step(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, "ovf_hold");

    for (int i = 0; i < 12; i++) begin
      step($urandom, $urandom, 1'($urandom), 1'($urandom), "random_gap");
    end

    // Asynchronous reset between edges with a result in flight.
    step(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    a        = 32'h1111_1111;
    b        = 32'h2222_2222;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset");
    @(posedge clk);
    #1;
    chk("reset_in_flight");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    step(32'h0, 32'h0, 1'b0, 1'b0, "post_reset_idle");
    step(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, "post_reset_sum");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
